// File: rtl/stage_sprite_writer.sv
// rtl/stage_sprite_writer.sv - three-plane sprite row memory with pixel read-modify-write, bulk clear and draw-side read port
// One internal RMW port serves pixel writes and clears; the draw port reads independently with one cycle of latency.
module stage_sprite_writer #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [1:0]    wr_blockNumber,
  input  logic [4:0]    wr_x,
  input  logic [4:0]    wr_y,
  input  logic [2:0]    wr_rgb,
  input  logic          clr_req,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dataR,
  output logic [DW-1:0] rd_dataG,
  output logic [DW-1:0] rd_dataB
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [4:0]    x_q;
  logic [2:0]    rgb_q;
  logic [6:0]    clr_cnt_q;
  logic          done_q;

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] mem_g [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  logic [DW-1:0] old_r_q, old_g_q, old_b_q;
  logic [DW-1:0] new_r_d, new_g_d, new_b_d;
  logic [DW-1:0] bit_mask;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] clr_addr;

  // Block index lands above the 5-bit row index, i.e. y + 32*block.
  assign wr_addr  = AW'({wr_blockNumber, wr_y});
  assign clr_addr = AW'(clr_cnt_q);

  assign bit_mask = DW'(1) << x_q;
  assign new_r_d  = (old_r_q & ~bit_mask) | ({DW{rgb_q[2]}} & bit_mask);
  assign new_g_d  = (old_g_q & ~bit_mask) | ({DW{rgb_q[1]}} & bit_mask);
  assign new_b_d  = (old_b_q & ~bit_mask) | ({DW{rgb_q[0]}} & bit_mask);

  assign wr_ready = (state_q == IDLE) & ~rst;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      x_q       <= '0;
      rgb_q     <= '0;
      clr_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Clear has priority; a simultaneous write is dropped, not queued.
          if (clr_req) begin
            state_q   <= CLR;
            clr_cnt_q <= '0;
          end else if (wr_valid) begin
            addr_q  <= wr_addr;
            x_q     <= wr_x;
            rgb_q   <= wr_rgb;
            state_q <= RD;
          end
        end
        RD: state_q <= WR;
        WR: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        CLR: begin
          if (clr_cnt_q == 7'd127) begin
            state_q   <= IDLE;
            done_q    <= 1'b1;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 7'd1;
          end
        end
      endcase
    end
  end

  // Memory contents survive reset; rst only blocks a write on an edge it overlaps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == RD) begin
        old_r_q <= mem_r[addr_q];
        old_g_q <= mem_g[addr_q];
        old_b_q <= mem_b[addr_q];
      end
      if (state_q == WR) begin
        mem_r[addr_q] <= new_r_d;
        mem_g[addr_q] <= new_g_d;
        mem_b[addr_q] <= new_b_d;
      end else if (state_q == CLR) begin
        mem_r[clr_addr] <= '0;
        mem_g[clr_addr] <= '0;
        mem_b[clr_addr] <= '0;
      end
    end
  end

  // Draw port sees pre-write data when it hits the address being committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_dataR <= '0;
      rd_dataG <= '0;
      rd_dataB <= '0;
    end else begin
      rd_dataR <= mem_r[rd_addr];
      rd_dataG <= mem_g[rd_addr];
      rd_dataB <= mem_b[rd_addr];
    end
  end

endmodule

// File: tb/tb_stage_sprite_writer.sv
// tb/tb_stage_sprite_writer.sv - directed self-checking bench for stage_sprite_writer
module tb_stage_sprite_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_blockNumber;
  logic [4:0]  wr_x;
  logic [4:0]  wr_y;
  logic [2:0]  wr_rgb;
  logic        clr_req;
  logic        busy;
  logic        done;
  logic [6:0]  rd_addr;
  logic [31:0] rd_dataR;
  logic [31:0] rd_dataG;
  logic [31:0] rd_dataB;

  int n_checks = 0;
  int n_errors = 0;

  stage_sprite_writer #(.AW(7), .DW(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_blockNumber (wr_blockNumber),
    .wr_x           (wr_x),
    .wr_y           (wr_y),
    .wr_rgb         (wr_rgb),
    .clr_req        (clr_req),
    .busy           (busy),
    .done           (done),
    .rd_addr        (rd_addr),
    .rd_dataR       (rd_dataR),
    .rd_dataG       (rd_dataG),
    .rd_dataB       (rd_dataB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_word(input logic [6:0] a);
    rd_addr = a;
    tick();
  endtask

  // Edges counted from the accept edge inclusive up to the edge that raises done.
  task automatic do_write(input logic [1:0] b, input logic [4:0] y, input logic [4:0] x,
                          input logic [2:0] c);
    int lat;
    check("wr_ready_pre", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1; wr_blockNumber = b; wr_y = y; wr_x = x; wr_rgb = c;
    tick();
    wr_valid = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("wr_latency", lat, 3);
  endtask

  task automatic run_clear(input bit with_wr, output int busy_n, output int done_n,
                           output int nrdy_n);
    busy_n = 0; done_n = 0; nrdy_n = 0;
    clr_req = 1'b1;
    wr_valid = with_wr; wr_blockNumber = 2'd2; wr_y = 5'd5; wr_x = 5'd7; wr_rgb = 3'b111;
    tick();
    clr_req = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 140; i++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      if (!wr_ready) nrdy_n++;
      if (with_wr && i >= 10 && i < 20) begin
        wr_valid = 1'b1; wr_blockNumber = 2'd0; wr_y = 5'd3; wr_x = 5'd4; wr_rgb = 3'b111;
        clr_req = (i == 15);
      end else begin
        wr_valid = 1'b0;
        clr_req = 1'b0;
      end
      tick();
    end
    wr_valid = 1'b0; clr_req = 1'b0;
  endtask

  initial begin
    int bn, dn, rn;
    logic [31:0] exp_w;
    rst = 1'b1; wr_valid = 1'b0; wr_blockNumber = '0; wr_x = '0; wr_y = '0; wr_rgb = '0;
    clr_req = 1'b0; rd_addr = '0;
    tick(); tick();
    check("rst_ready",  {31'd0, wr_ready}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_rdR",    rd_dataR, 32'd0);
    check("rst_rdG",    rd_dataG, 32'd0);
    check("rst_rdB",    rd_dataB, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready",  {31'd0, wr_ready}, 32'd1);
    tick();

    run_clear(1'b0, bn, dn, rn);
    check("clr_busy_cycles", bn, 128);
    check("clr_done_pulses", dn, 1);
    for (int a = 0; a < 128; a++) begin
      rd_word(7'(a));
      check("clr_zero", rd_dataR | rd_dataG | rd_dataB, 32'd0);
    end

    do_write(2'd2, 5'd5, 5'd31, 3'b101);
    rd_word(7'd69);
    check("w1_R", rd_dataR, 32'h80000000);
    check("w1_G", rd_dataG, 32'h00000000);
    check("w1_B", rd_dataB, 32'h80000000);

    do_write(2'd2, 5'd5, 5'd0, 3'b010);
    rd_word(7'd69);
    check("w2_R", rd_dataR, 32'h80000000);
    check("w2_G", rd_dataG, 32'h00000001);
    check("w2_B", rd_dataB, 32'h80000000);

    rd_addr = 7'd69;
    wr_valid = 1'b1; wr_blockNumber = 2'd2; wr_y = 5'd5; wr_x = 5'd1; wr_rgb = 3'b111;
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    check("rw_done",  {31'd0, done}, 32'd1);
    check("rw_old_R", rd_dataR, 32'h80000000);
    check("rw_old_G", rd_dataG, 32'h00000001);
    check("rw_old_B", rd_dataB, 32'h80000000);
    tick();
    check("rw_new_R", rd_dataR, 32'h80000002);
    check("rw_new_G", rd_dataG, 32'h00000003);
    check("rw_new_B", rd_dataB, 32'h80000002);

    run_clear(1'b1, bn, dn, rn);
    check("both_busy_cycles", bn, 128);
    check("both_done_pulses", dn, 1);
    check("both_ready_low",   rn, 128);
    check("both_idle", {31'd0, busy}, 32'd0);
    rd_word(7'd69);
    check("both_69_zero", rd_dataR | rd_dataG | rd_dataB, 32'd0);
    rd_word(7'd3);
    check("busy_wr_ignored", rd_dataR | rd_dataG | rd_dataB, 32'd0);

    for (int a = 0; a < 128; a++) begin
      logic [6:0] av;
      av = 7'(a);
      do_write(av[6:5], av[4:0], av[4:0], 3'b111);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (40) tick();
    check("mid_clr_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_done",  {31'd0, done}, 32'd0);
    check("mid_rst_ready", {31'd0, wr_ready}, 32'd0);
    check("mid_rst_rdR",   rd_dataR, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, wr_ready}, 32'd1);
    check("post_rst_busy",  {31'd0, busy}, 32'd0);
    for (int a = 0; a < 128; a++) begin
      rd_word(7'(a));
      exp_w = (a < 40) ? 32'd0 : (32'd1 << (a % 32));
      check("part_R", rd_dataR, exp_w);
      check("part_G", rd_dataG, exp_w);
      check("part_B", rd_dataB, exp_w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage_sprite_writer.md
STAGE_SPRITE_WRITER -- requirements
Module: stage_sprite_writer

Interface
REQ-001 The block SHALL have parameter AW, default 7, meaning the sprite memory address width (4 blocks x 32 rows).
REQ-002 The block SHALL have parameter DW, default 32, meaning the sprite row width in pixels.
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port wr_valid  input  1  pixel-write request.
REQ-006 The block SHALL have port wr_ready  output  1  block can accept a pixel write.
REQ-007 The block SHALL have port wr_blockNumber  input  2  sprite block index 0..3.
REQ-008 The block SHALL have port wr_x  input  5  pixel column, bit index within the row.
REQ-009 The block SHALL have port wr_y  input  5  pixel row within the block.
REQ-010 The block SHALL have port wr_rgb  input  3  pixel colour bits: [2]=R, [1]=G, [0]=B.
REQ-011 The block SHALL have port clr_req  input  1  request to zero all sprite memory.
REQ-012 The block SHALL have port busy  output  1  high while a write or clear is in progress.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse when a write or clear completes.
REQ-014 The block SHALL have port rd_addr  input  AW  draw-side read address.
REQ-015 The block SHALL have ports rd_dataR, rd_dataG and rd_dataB  output  DW each, giving the draw-side R, G and B row words.

Function
REQ-016 The block SHALL contain three AW x DW memories (R, G and B) with one internal read-modify-write port and one independent draw-side read port.
REQ-017 The write address SHALL be computed as wr_y + 32*wr_blockNumber, truncated to AW bits.
REQ-018 The FSM SHALL have exactly the states IDLE, RD, WR and CLR.
REQ-019 wr_ready SHALL equal (state==IDLE) and be low while rst is high.
REQ-020 busy SHALL be high when the state is not IDLE.
REQ-021 In IDLE, if clr_req=1 then the block SHALL enter CLR; else if wr_valid=1 then it SHALL enter RD.
REQ-022 When clr_req and wr_valid are high in the same cycle, clear SHALL win and the write SHALL not be accepted.
REQ-023 On accept, the block SHALL register the address, wr_x and wr_rgb, then enter RD.
REQ-024 RD SHALL read the three words at the registered address, and the block SHALL go to WR on the next edge.
REQ-025 WR SHALL write back each word with only bit wr_x replaced by its wr_rgb bit, leaving all other bits unchanged.
REQ-026 WR SHALL return to IDLE on the next edge and pulse done for exactly one cycle in that IDLE cycle.
REQ-027 Accept-to-commit SHALL be 3 edges: accept at edge T, RD read at T+1, memory updated at T+2, done high during the T+2..T+3 cycle.
REQ-028 A new accept SHALL be possible in the cycle in which done is high.
REQ-029 CLR SHALL run a 7-bit counter from 0 to 127, writing 0 to all three memories at one address per cycle.
REQ-030 After the write at address 127, CLR SHALL go to IDLE and pulse done; a clear SHALL take 128 cycles in CLR.
REQ-031 clr_req and wr_valid SHALL be ignored and not latched while busy.
REQ-032 The draw-side read SHALL be registered with 1-cycle latency: rd_data* at edge N+1 reflects rd_addr at edge N.
REQ-033 A draw-side read of the address being written on the same edge SHALL return the old data.
REQ-034 wr_x and wr_y SHALL be used modulo 32 with no error flag.

Reset
REQ-035 When rst is asserted, the state SHALL go to IDLE immediately, busy=0, done=0, the clear counter=0 and rd_dataR/G/B=0.
REQ-036 Memory contents SHALL not be altered by reset.
REQ-037 Reset during RD SHALL cause no write; reset during WR asserted before the edge SHALL cause no write; reset mid-CLR SHALL leave the already-cleared addresses zero and the rest unchanged.
REQ-038 After rst deasserts, wr_ready SHALL rise in the first cycle.

Verification
REQ-039 The bench SHALL check: clr_req pulse -> busy high 128 cycles, one done pulse, then reading rd_addr 0..127 gives all zeros on R, G and B.
REQ-040 The bench SHALL check: after clear, write block=2, y=5, x=31, rgb=3'b101 -> at addr 69, rd_dataR=32'h80000000, rd_dataG=0, rd_dataB=32'h80000000, and done occurs 3 edges after accept.
REQ-041 The bench SHALL check: second write block=2, y=5, x=0, rgb=3'b010 -> at addr 69, R=32'h80000000, G=32'h00000001, B=32'h80000000, so other bits are preserved.
REQ-042 The bench SHALL check: clr_req and wr_valid high together in IDLE -> clear runs, the write is dropped, and wr_ready stays low 128 cycles.
REQ-043 The bench SHALL check: a draw read of addr 69 on the same edge as WR commit -> old word returned, and the new word appears on the next read.
REQ-044 The bench SHALL check: rst pulsed at clear counter=40 -> addresses 0..39 zero, 40..127 unchanged, busy=0 and wr_ready=1 after release.
